// File: rtl/sync_sample_fifo.sv
// Single-clock FIFO for packed L/R audio sample words.
// Popped words land in a held register so the I2S shifter reloads from a stable value.
module sync_sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_74a,
    input  logic             reset_n,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_s,
    output logic             empty,
    output logic             full,
    output logic [$clog2(DEPTH):0] count,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_s_q, data_s_d;
    logic             overflow_q, overflow_d;

    logic pop;
    logic push;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop  = read_en && (count_q != '0);
    assign push = write_en && ((count_q != FullCount) || pop);

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        data_s_d   = data_s_q;
        overflow_d = write_en && !push;
        if (push) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d     = rp_q + AW'(1);
            data_s_d = mem[rp_q];
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            data_s_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            data_s_q   <= data_s_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_74a) begin
        if (reset_n && push) begin
            mem[wp_q] <= data;
        end
    end

    assign data_s   = data_s_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FullCount);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sync_sample_fifo.sv
// Directed bench for sync_sample_fifo with a queue scoreboard of expected pops.
module tb_sync_sample_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk_74a = 1'b0;
    logic             reset_n;
    logic             write_en;
    logic [WIDTH-1:0] data;
    logic             read_en;
    logic [WIDTH-1:0] data_s;
    logic             empty;
    logic             full;
    logic [$clog2(DEPTH):0] count;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_data_s;
    logic             exp_ovf;

    sync_sample_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk_74a (clk_74a),
        .reset_n (reset_n),
        .write_en(write_en),
        .data    (data),
        .read_en (read_en),
        .data_s  (data_s),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".data_s"}, data_s, exp_data_s);
        check({tag, ".count"}, 32'(count), 32'(sb.size()));
        check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(sb.size() == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
    task automatic step(input logic we, input logic [31:0] d, input logic re, input string tag);
        bit m_pop;
        bit m_push;
        write_en = we;
        data     = d;
        read_en  = re;
        m_pop  = re && (sb.size() != 0);
        m_push = we && ((sb.size() < DEPTH) || m_pop);
        if (m_pop) exp_data_s = sb.pop_front();
        if (m_push) sb.push_back(d);
        exp_ovf = we && !m_push;
        @(posedge clk_74a);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_state(tag);
    endtask

    // Reset with both strobes high to show reset wins over them.
    task automatic do_reset(input string tag);
        reset_n  = 1'b0;
        write_en = 1'b1;
        read_en  = 1'b1;
        data     = 32'hDEAD_BEEF;
        @(posedge clk_74a);
        #1;
        reset_n  = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        sb.delete();
        exp_data_s = '0;
        exp_ovf    = 1'b0;
        check_state(tag);
    endtask

    initial begin
        reset_n    = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        data       = '0;
        exp_data_s = '0;
        exp_ovf    = 1'b0;

        do_reset("reset");
        step(0, 0, 0, "idle");
        for (int i = 0; i < 3; i++) step(0, 0, 1, "pop_empty");

        step(1, 32'h1234_ABCD, 0, "single_push");
        step(0, 0, 1, "single_pop");
        for (int i = 0; i < 10; i++) step(0, 0, 0, "single_hold");

        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, "fill");
        step(1, 32'h5, 0, "overflow_push");
        step(0, 0, 0, "overflow_clear");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "drain");

        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, "refill");
        step(1, 32'hAA, 1, "full_push_pop");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "drain_aa");

        step(1, 32'h77, 1, "empty_push_pop");
        step(0, 0, 1, "pop_77");

        step(1, 32'hC000_0000, 0, "stream_prime");
        for (int i = 1; i < 20; i++) step(1, 32'hC000_0000 + 32'(i * 3), 1, "stream");
        step(1, 32'hBEEF_0001, 0, "pre_reset_push");
        do_reset("mid_reset");
        step(1, 32'h0F0F_F0F0, 0, "post_reset_push");
        step(0, 0, 1, "post_reset_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
